// File: rtl/midi_pkg.sv
// -----------------------------------------------------------------------------
// midi_pkg
// Shared definitions for the Wishbone MIDI transmitter: register offsets
// (wb_adr_i[3:2]), STAT/CTRL bit positions, transmitter FSM encoding and the
// MIDI message-length rule.
// Optional feature used by wb_midi_tx: MIDI_RUNNING_STATUS_EN.
// -----------------------------------------------------------------------------
package midi_pkg;

   // Register word offsets
   localparam logic [1:0] REG_DATA = 2'd0;
   localparam logic [1:0] REG_STAT = 2'd1;
   localparam logic [1:0] REG_CTRL = 2'd2;
   localparam logic [1:0] REG_NONE = 2'd3;

   // STAT bit positions
   localparam int STAT_BUSY    = 0;
   localparam int STAT_EMPTY   = 1;
   localparam int STAT_FULL    = 2;
   localparam int STAT_OVF     = 3;
   localparam int STAT_LVL_LSB = 16;

   // CTRL bit positions
   localparam int CTRL_IRQ_EN  = 0;
   localparam int CTRL_THR_LSB = 8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_START = 3'd2,
      ST_BITS  = 3'd3,
      ST_STOP  = 3'd4
   } tx_state_e;

   // Number of bytes in a message, selected by its status byte.
   // Values below 0x80 are a single raw byte.
   function automatic logic [1:0] msg_len(input logic [7:0] st);
      logic [1:0] len;
      len = 2'd1;
      if (st[7] == 1'b0) begin
         len = 2'd1;
      end else begin
         case (st[7:4])
            4'h8, 4'h9, 4'hA, 4'hB, 4'hE: len = 2'd3;
            4'hC, 4'hD:                   len = 2'd2;
            4'hF: begin
               case (st[3:0])
                  4'h1, 4'h3: len = 2'd2;
                  4'h2:       len = 2'd3;
                  default:    len = 2'd1;
               endcase
            end
            default: len = 2'd1;
         endcase
      end
      return len;
   endfunction

endpackage

// File: rtl/midi_msg_fifo.sv
// -----------------------------------------------------------------------------
// midi_msg_fifo
// Message FIFO, WIDTH bits wide and DEPTH (power of two) entries deep.
// Wrapping pointers carry one extra MSB so full and empty are distinguishable.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   wr_en, wr_data    push (ignored when full)
//   rd_en, rd_data    pop (ignored when empty); rd_data shows the head entry
//   full, empty       occupancy flags
//   level             number of stored entries, 0..DEPTH
// -----------------------------------------------------------------------------
module midi_msg_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 24
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             push_s, pop_s;

   assign full    = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}});
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign level   = wr_ptr_q - rd_ptr_q;
   assign rd_data = mem_q[rd_ptr_q[AW-1:0]];
   assign push_s  = wr_en & ~full;
   assign pop_s   = rd_en & ~empty;

   // Pointer advance for accepted pushes and pops
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_s) begin
         wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
   end

   // Pointer registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage array; contents need no reset since the pointers gate visibility
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
      end
   end

endmodule

// File: rtl/wb_midi_tx.sv
// -----------------------------------------------------------------------------
// wb_midi_tx
// Wishbone slave that queues 3-byte MIDI messages and serialises them as
// 8N1 frames on midi_txd at clk_freq/baud cycles per bit.
// Optional feature: define MIDI_RUNNING_STATUS_EN to omit a channel status
// byte (0x80-0xEF) equal to the previously transmitted one.
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   wb_adr_i/dat_i/dat_o/sel_i/
//   stb_i/cyc_i/we_i/ack_o          Wishbone slave (DATA, STAT, CTRL)
//   midi_txd                        serial output, idle high
//   status, data1, data2            bytes of the last completed message
//   irq                             level interrupt: irq_en & level<=threshold
// -----------------------------------------------------------------------------
module wb_midi_tx
   import midi_pkg::*;
#(
   parameter int clk_freq   = 100000000,
   parameter int baud       = 31250,
   parameter int fifo_depth = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] wb_adr_i,
   input  logic [31:0] wb_dat_i,
   output logic [31:0] wb_dat_o,
   input  logic [3:0]  wb_sel_i,
   input  logic        wb_stb_i,
   input  logic        wb_cyc_i,
   input  logic        wb_we_i,
   output logic        wb_ack_o,
   output logic        midi_txd,
   output logic [7:0]  status,
   output logic [7:0]  data1,
   output logic [7:0]  data2,
   output logic        irq
);

   localparam int BIT_CYC = clk_freq / baud;
   localparam int CW      = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
   localparam logic [CW-1:0] BIT_RELOAD = CW'(BIT_CYC - 1);
   localparam int AW      = $clog2(fifo_depth);

   // Wishbone side
   logic        wb_req_s;
   logic        ack_q, ack_d;
   logic [31:0] dat_q, dat_d, rdata_s;
   logic        ovf_q, ovf_d;
   logic        irq_en_q, irq_en_d;
   logic [7:0]  thr_q, thr_d;
   logic        irq_q, irq_d;
   logic        unused_s;

   // FIFO
   logic        fifo_wr_s, fifo_rd_s, fifo_full_s, fifo_empty_s;
   logic [23:0] fifo_rd_data_s;
   logic [AW:0] fifo_level_s;
   logic [8:0]  level9_s;

   // Transmitter
   tx_state_e     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0]    sh_q, sh_d;
   logic [2:0]    bitn_q, bitn_d;
   logic [15:0]   pend_q, pend_d;
   logic [1:0]    nrem_q, nrem_d;
   logic [23:0]   msg_q, msg_d;
   logic [23:0]   last_q, last_d;
   logic          txd_q, txd_d;
   logic          bit_end_s, busy_s, omit_s;
   logic [7:0]    st_s, d1_s, d2_s;
   logic [1:0]    len_s;

   assign wb_req_s  = wb_stb_i & wb_cyc_i & ~ack_q;
   assign level9_s  = 9'(fifo_level_s);
   assign busy_s    = (state_q != ST_IDLE);
   assign bit_end_s = (cnt_q == '0);
   assign st_s      = fifo_rd_data_s[23:16];
   assign d1_s      = fifo_rd_data_s[15:8];
   assign d2_s      = fifo_rd_data_s[7:0];
   assign len_s     = msg_len(st_s);
   assign unused_s  = ^{wb_adr_i[31:4], wb_adr_i[1:0], wb_sel_i, wb_dat_i[31:24]};

   midi_msg_fifo #(.DEPTH(fifo_depth), .WIDTH(24)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (fifo_wr_s),
      .wr_data (wb_dat_i[23:0]),
      .rd_en   (fifo_rd_s),
      .rd_data (fifo_rd_data_s),
      .full    (fifo_full_s),
      .empty   (fifo_empty_s),
      .level   (fifo_level_s)
   );

   // Register read multiplexer
   always_comb begin
      rdata_s = 32'h0;
      case (wb_adr_i[3:2])
         REG_STAT: begin
            rdata_s[STAT_LVL_LSB +: 8] = level9_s[7:0];
            rdata_s[STAT_OVF]          = ovf_q;
            rdata_s[STAT_FULL]         = fifo_full_s;
            rdata_s[STAT_EMPTY]        = fifo_empty_s;
            rdata_s[STAT_BUSY]         = busy_s;
         end
         REG_CTRL: begin
            rdata_s[CTRL_IRQ_EN]        = irq_en_q;
            rdata_s[CTRL_THR_LSB +: 8]  = thr_q;
         end
         default: rdata_s = 32'h0;
      endcase
   end

   // Register writes, single-cycle ack, read data capture and interrupt level
   always_comb begin
      ovf_d     = ovf_q;
      irq_en_d  = irq_en_q;
      thr_d     = thr_q;
      fifo_wr_s = 1'b0;
      ack_d     = wb_req_s;
      dat_d     = wb_req_s ? rdata_s : 32'h0;
      if (wb_req_s && wb_we_i) begin
         case (wb_adr_i[3:2])
            REG_DATA: begin
               // A full FIFO drops the message but remembers it happened
               if (fifo_full_s) begin
                  ovf_d = 1'b1;
               end else begin
                  fifo_wr_s = 1'b1;
               end
            end
            REG_STAT: begin
               if (wb_dat_i[STAT_OVF]) begin
                  ovf_d = 1'b0;
               end else begin
                  ovf_d = ovf_q;
               end
            end
            REG_CTRL: begin
               irq_en_d = wb_dat_i[CTRL_IRQ_EN];
               thr_d    = wb_dat_i[CTRL_THR_LSB +: 8];
            end
            default: ovf_d = ovf_q;
         endcase
      end else begin
         fifo_wr_s = 1'b0;
      end
      irq_d = irq_en_q & (level9_s <= {1'b0, thr_q});
   end

   // Running-status suppression decision for the entry being loaded
`ifdef MIDI_RUNNING_STATUS_EN
   logic [7:0] rs_q, rs_d;

   // Track the last channel status handed to the serialiser
   always_comb begin
      omit_s = (st_s >= 8'h80) && (st_s <= 8'hEF) && (st_s == rs_q);
      rs_d   = rs_q;
      if (state_q == ST_LOAD) begin
         if ((st_s >= 8'h80) && (st_s <= 8'hEF)) begin
            rs_d = st_s;
         end else if ((st_s >= 8'hF0) && (st_s <= 8'hF7)) begin
            rs_d = 8'h00;
         end else begin
            rs_d = rs_q;
         end
      end else begin
         rs_d = rs_q;
      end
   end

   // Running-status register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rs_q <= 8'h00;
      end else begin
         rs_q <= rs_d;
      end
   end
`else
   assign omit_s = 1'b0;
`endif

   // Transmitter next-state logic: one frame per byte, bytes of a message back to back
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      sh_d      = sh_q;
      bitn_d    = bitn_q;
      pend_d    = pend_q;
      nrem_d    = nrem_q;
      msg_d     = msg_q;
      last_d    = last_q;
      fifo_rd_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty_s) begin
               state_d = ST_LOAD;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOAD: begin
            fifo_rd_s = 1'b1;
            msg_d     = fifo_rd_data_s;
            cnt_d     = BIT_RELOAD;
            state_d   = ST_START;
            // pend holds the bytes still to go, next one in the low byte
            if (omit_s) begin
               sh_d   = d1_s;
               pend_d = {8'h00, d2_s};
               nrem_d = len_s - 2'd2;
            end else begin
               sh_d   = st_s;
               pend_d = {d2_s, d1_s};
               nrem_d = len_s - 2'd1;
            end
         end
         ST_START: begin
            if (bit_end_s) begin
               cnt_d   = BIT_RELOAD;
               bitn_d  = 3'd0;
               state_d = ST_BITS;
            end else begin
               cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
            end
         end
         ST_BITS: begin
            if (bit_end_s) begin
               cnt_d = BIT_RELOAD;
               if (bitn_q == 3'd7) begin
                  state_d = ST_STOP;
               end else begin
                  sh_d   = {1'b0, sh_q[7:1]};
                  bitn_d = bitn_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
            end
         end
         ST_STOP: begin
            if (bit_end_s) begin
               cnt_d = BIT_RELOAD;
               if (nrem_q != 2'd0) begin
                  sh_d    = pend_q[7:0];
                  pend_d  = {8'h00, pend_q[15:8]};
                  nrem_d  = nrem_q - 2'd1;
                  state_d = ST_START;
               end else begin
                  last_d  = msg_q;
                  state_d = ST_IDLE;
               end
            end else begin
               cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Line level follows the state being entered so it is registered in step
      case (state_d)
         ST_START: txd_d = 1'b0;
         ST_BITS:  txd_d = sh_d[0];
         default:  txd_d = 1'b1;
      endcase
   end

   // All control and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ack_q    <= 1'b0;
         dat_q    <= 32'h0;
         ovf_q    <= 1'b0;
         irq_en_q <= 1'b0;
         thr_q    <= 8'h00;
         irq_q    <= 1'b0;
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         sh_q     <= 8'h00;
         bitn_q   <= 3'd0;
         pend_q   <= 16'h0000;
         nrem_q   <= 2'd0;
         msg_q    <= 24'h000000;
         last_q   <= 24'h000000;
         txd_q    <= 1'b1;
      end else begin
         ack_q    <= ack_d;
         dat_q    <= dat_d;
         ovf_q    <= ovf_d;
         irq_en_q <= irq_en_d;
         thr_q    <= thr_d;
         irq_q    <= irq_d;
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         sh_q     <= sh_d;
         bitn_q   <= bitn_d;
         pend_q   <= pend_d;
         nrem_q   <= nrem_d;
         msg_q    <= msg_d;
         last_q   <= last_d;
         txd_q    <= txd_d;
      end
   end

   assign wb_ack_o = ack_q;
   assign wb_dat_o = dat_q;
   assign midi_txd = txd_q;
   assign irq      = irq_q;
   assign status   = last_q[23:16];
   assign data1    = last_q[15:8];
   assign data2    = last_q[7:0];

endmodule

// File: tb/tb_wb_midi_tx.sv
// Self-checking bench for wb_midi_tx: a serial receiver decodes midi_txd and
// the received bytes are compared with a message-level reference model.
module tb_wb_midi_tx;

   localparam int CLK_FREQ = 160;
   localparam int BAUD     = 10;
   localparam int DEPTH    = 4;
   localparam int BT       = CLK_FREQ / BAUD;

   localparam logic [1:0] A_DATA = 2'd0;
   localparam logic [1:0] A_STAT = 2'd1;
   localparam logic [1:0] A_CTRL = 2'd2;
   localparam logic [1:0] A_NONE = 2'd3;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
   logic [3:0]  wb_sel_i;
   logic        wb_stb_i, wb_cyc_i, wb_we_i, wb_ack_o;
   logic        midi_txd, irq;
   logic [7:0]  status, data1, data2;

   int n_checks = 0;
   int n_fail   = 0;

   logic [8:0]  rx_q [$];
   logic [7:0]  exp_q [$];
   logic [23:0] last_msg;
   logic [7:0]  mon_b;
   logic        mon_stop;
`ifdef MIDI_RUNNING_STATUS_EN
   logic [7:0]  rs_m;
`endif

   wb_midi_tx #(.clk_freq(CLK_FREQ), .baud(BAUD), .fifo_depth(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
      .wb_sel_i(wb_sel_i), .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i),
      .wb_we_i(wb_we_i), .wb_ack_o(wb_ack_o),
      .midi_txd(midi_txd), .status(status), .data1(data1), .data2(data2),
      .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // Serial receiver: samples mid-bit, records {stop_bit, data}
   initial begin
      forever begin
         @(negedge clk);
         if (!reset && midi_txd === 1'b0) begin
            repeat (BT/2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (BT) @(negedge clk);
               mon_b[i] = midi_txd;
            end
            repeat (BT) @(negedge clk);
            mon_stop = midi_txd;
            rx_q.push_back({mon_stop, mon_b});
         end
      end
   end

   // Reference model: bytes that a message should put on the wire
   task automatic model_push(input logic [23:0] m);
      logic [7:0] st, d1, d2;
      int n;
      bit skip;
      st = m[23:16]; d1 = m[15:8]; d2 = m[7:0];
      skip = 1'b0;
      if (st < 8'h80)                     n = 1;
      else if (st <= 8'hBF)               n = 3;
      else if (st <= 8'hDF)               n = 2;
      else if (st <= 8'hEF)               n = 3;
      else if (st == 8'hF2)               n = 3;
      else if (st == 8'hF1 || st == 8'hF3) n = 2;
      else                                n = 1;
`ifdef MIDI_RUNNING_STATUS_EN
      if (st >= 8'h80 && st <= 8'hEF) begin
         skip = (st == rs_m);
         rs_m = st;
      end else if (st >= 8'hF0 && st <= 8'hF7) begin
         rs_m = 8'h00;
      end
`endif
      if (!skip) exp_q.push_back(st);
      if (n >= 2) exp_q.push_back(d1);
      if (n == 3) exp_q.push_back(d2);
      last_msg = m;
   endtask

   task automatic wb_access(input logic we, input logic [1:0] a, input logic [31:0] wd,
                            output logic [31:0] rd);
      int n;
      @(negedge clk);
      wb_adr_i = {28'h0, a, 2'b00};
      wb_dat_i = wd;
      wb_we_i  = we;
      wb_sel_i = 4'hF;
      wb_stb_i = 1'b1;
      wb_cyc_i = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (wb_ack_o !== 1'b1 && n < 8);
      check("ack_latency", n, 1);
      rd = wb_dat_o;
      wb_stb_i = 1'b0;
      wb_cyc_i = 1'b0;
      wb_we_i  = 1'b0;
      @(negedge clk);
      check("ack_one_cycle", wb_ack_o, 1'b0);
   endtask

   task automatic wb_write(input logic [1:0] a, input logic [31:0] wd);
      logic [31:0] dummy;
      wb_access(1'b1, a, wd, dummy);
   endtask

   task automatic wb_read(input logic [1:0] a, output logic [31:0] rd);
      wb_access(1'b0, a, 32'h0, rd);
   endtask

   // Waits for FIFO space, then writes and models one message
   task automatic send_msg(input logic [23:0] m);
      logic [31:0] s;
      int n;
      n = 0;
      wb_read(A_STAT, s);
      while (s[2] && n < 400) begin
         wb_read(A_STAT, s);
         n++;
      end
      check("fifo_space", s[2], 1'b0);
      wb_write(A_DATA, {8'h00, m});
      model_push(m);
   endtask

   task automatic wait_idle(input string tag);
      logic [31:0] s;
      int n;
      n = 0;
      wb_read(A_STAT, s);
      while ((s[0] || !s[1]) && n < 4000) begin
         wb_read(A_STAT, s);
         n++;
      end
      check({tag, "_idle"}, s[1:0], 2'b10);
      repeat (4) @(negedge clk);
   endtask

   task automatic compare_stream(input string tag);
      logic [8:0] r;
      logic [7:0] e;
      check({tag, "_nbytes"}, rx_q.size(), exp_q.size());
      while (rx_q.size() > 0 && exp_q.size() > 0) begin
         r = rx_q.pop_front();
         e = exp_q.pop_front();
         check({tag, "_byte"}, r[7:0], e);
         check({tag, "_stop"}, r[8], 1'b1);
      end
      rx_q.delete();
      exp_q.delete();
      check({tag, "_last"}, {status, data1, data2}, last_msg);
   endtask

   logic [31:0] rd;
   logic [23:0] m;
   logic [7:0]  pool [4] = '{8'h90, 8'h91, 8'hC0, 8'hE0};
   int          n;

   initial begin
      reset = 1'b1;
      wb_adr_i = 32'h0; wb_dat_i = 32'h0; wb_sel_i = 4'h0;
      wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
      last_msg = 24'h0;
`ifdef MIDI_RUNNING_STATUS_EN
      rs_m = 8'h00;
`endif
      repeat (3) @(negedge clk);
      check("rst_txd", midi_txd, 1'b1);
      check("rst_ack", wb_ack_o, 1'b0);
      check("rst_dat", wb_dat_o, 32'h0);
      check("rst_outs", {status, data1, data2, 7'h0, irq}, 32'h0);
      reset = 1'b0;
      @(negedge clk);
      wb_read(A_STAT, rd);  check("rst_stat", rd, 32'h0000_0002);
      wb_read(A_CTRL, rd);  check("rst_ctrl", rd, 32'h0);
      wb_write(A_NONE, 32'hFFFF_FFFF);
      wb_read(A_NONE, rd);  check("reg3_zero", rd, 32'h0);

      // One 3-byte message: 30 bit times from start edge to status update
      wb_write(A_DATA, 32'h0090_3C7F);
      model_push(24'h903C7F);
      n = 0;
      while (midi_txd !== 1'b0 && n < 100) begin @(negedge clk); n++; end
      check("start_seen", midi_txd, 1'b0);
      n = 0;
      while (status !== 8'h90 && n < 1000) begin @(negedge clk); n++; end
      check("msg_cycles", n, 30 * BT);
      wait_idle("m1");
      compare_stream("m1");

      // Length rules and running-status sequence
      send_msg(24'hC00512);
      send_msg(24'hF81234);
      wait_idle("len");
      compare_stream("len");
      send_msg(24'h903C7F);
      send_msg(24'h903E7F);
      send_msg(24'hF80000);
      send_msg(24'h903E7F);
      send_msg(24'hF20102);
      send_msg(24'h903C7F);
      wait_idle("rs");
      compare_stream("rs");

      // Random messages
      for (int i = 0; i < 24; i++) begin
         n = $urandom_range(0, 9);
         if (n < 3)      m[23:16] = pool[$urandom_range(0, 3)];
         else if (n < 5) m[23:16] = 8'($urandom_range(8'hF0, 8'hFF));
         else            m[23:16] = 8'($urandom_range(0, 255));
         m[15:0] = 16'($urandom);
         send_msg(m);
      end
      wait_idle("rnd");
      compare_stream("rnd");

      // Overflow: first write is taken by the transmitter, DEPTH more fill the FIFO
      for (int i = 0; i < DEPTH + 2; i++) begin
         m = {8'(8'hF8 + i), 8'(i), 8'h55};
         wb_write(A_DATA, {8'h00, m});
         if (i < DEPTH + 1) model_push(m);
      end
      wb_read(A_STAT, rd);
      check("ovf_stat", rd, (32'(DEPTH) << 16) | 32'h0000_000D);
      wb_write(A_STAT, 32'h0000_0008);
      wb_read(A_STAT, rd);
      check("ovf_clear", rd, (32'(DEPTH) << 16) | 32'h0000_0005);
      wait_idle("ovf");
      compare_stream("ovf");

      // Interrupt threshold: level 3 after the first pop, irq rises at level 2
      for (int i = 0; i < 4; i++) send_msg({8'h80, 8'(i), 8'h40});
      wb_write(A_CTRL, 32'h0000_0201);
      wb_read(A_CTRL, rd);  check("ctrl_rb", rd, 32'h0000_0201);
      wb_read(A_STAT, rd);  check("irq_lvl3", rd, 32'h0003_0001);
      check("irq_low", irq, 1'b0);
      n = 0;
      while (irq !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
      check("irq_rise", irq, 1'b1);
      wb_read(A_STAT, rd);  check("irq_lvl2", rd, 32'h0002_0001);

      // Reset in the middle of a frame
      n = 0;
      while (midi_txd !== 1'b0 && n < 400) begin @(negedge clk); n++; end
      check("mid_frame", midi_txd, 1'b0);
      reset = 1'b1;
      #1;
      check("rst_abort_txd", midi_txd, 1'b1);
      @(negedge clk);
      check("rst_abort_txd_cyc", midi_txd, 1'b1);
      reset = 1'b0;
      @(negedge clk);
      wb_read(A_STAT, rd);  check("rst_abort_stat", rd, 32'h0000_0002);
      wb_read(A_CTRL, rd);  check("rst_abort_ctrl", rd, 32'h0);
      check("rst_abort_outs", {status, data1, data2, 7'h0, irq}, 32'h0);
      repeat (12 * BT) @(negedge clk);
      check("rst_stays_idle", midi_txd, 1'b1);
      rx_q.delete();
      exp_q.delete();
      last_msg = 24'h0;
`ifdef MIDI_RUNNING_STATUS_EN
      rs_m = 8'h00;
`endif

      // Empty FIFO with threshold 0 satisfies level <= threshold
      wb_write(A_CTRL, 32'h0000_0001);
      @(negedge clk);
      check("irq_thr0", irq, 1'b1);

      // After reset a channel status must be sent again in full
      send_msg(24'h903C7F);
      wait_idle("post_rst");
      compare_stream("post_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
